// File: rtl/sm2201_camac_cycle_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : sm2201_camac_cycle_sequencer_if
//  Purpose  : ISA request/response and CAMAC dataway signal bundle for the
//             SM2201 cycle sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
interface sm2201_camac_cycle_sequencer_if;
  // ISA request side
  logic        req_valid;
  logic        req_write;
  logic [11:0] req_addr;
  logic [15:0] req_wdata;
  logic        req_ready;
  // CAMAC dataway side
  logic [11:0] cb_addr;
  logic [15:0] cb_data_out;
  logic        cb_data_oe;
  logic [15:0] cb_data_in;
  logic        cb_b_b1;
  logic        cb_prr;
  logic        cb_zk4;
  // ISA response / LAM side
  logic        lam_ack;
  logic        isa_chrdy;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_timeout;
  logic        lam_pending;

  // Sequencer view
  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    input  cb_data_in, cb_prr, cb_zk4, lam_ack,
    output req_ready, cb_addr, cb_data_out, cb_data_oe, cb_b_b1,
    output isa_chrdy, rsp_valid, rsp_rdata, rsp_timeout, lam_pending
  );

  // ISA register stage / CAMAC responder view
  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    output cb_data_in, cb_prr, cb_zk4, lam_ack,
    input  req_ready, cb_addr, cb_data_out, cb_data_oe, cb_b_b1,
    input  isa_chrdy, rsp_valid, rsp_rdata, rsp_timeout, lam_pending
  );
endinterface
`default_nettype wire

// File: rtl/sm2201_camac_cycle_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : sm2201_camac_cycle_sequencer
//  Purpose  : Runs one CAMAC dataway cycle (setup, strobe, release) per ISA
//             request, with responder-ack timeout and a sticky LAM flag.
//  Revision : 1.0 - initial release
// ============================================================================
module sm2201_camac_cycle_sequencer #(
  parameter int SETUP_CYCLES   = 2,   // 1..15
  parameter int TIMEOUT_CYCLES = 255  // 2..255
) (
  input  wire logic                      isa_clk,
  input  wire logic                      isa_reset,
  sm2201_camac_cycle_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_STROBE  = 3'd2,
    S_RELEASE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [7:0] C_SETUP_LAST = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] C_TMO_LAST   = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_nxt;
  logic        r_to_flag;
  logic        w_to_flag_nxt;
  logic [15:0] r_rdata_cap;
  logic [15:0] w_rdata_cap_nxt;
  logic        w_accept;
  logic        w_write_nxt;
  logic        r_write;

  logic        r_prr_meta;
  logic        r_prr_s;
  logic        r_zk4_meta;
  logic        r_zk4_s;
  logic        r_zk4_prev;
  logic        w_zk4_fall;

  logic        r_req_ready;
  logic        r_cb_b_b1;
  logic        r_cb_data_oe;
  logic        r_isa_chrdy;
  logic        r_rsp_valid;
  logic        r_rsp_timeout;
  logic        r_lam_pending;
  logic [11:0] r_cb_addr;
  logic [15:0] r_cb_data_out;
  logic [15:0] r_rsp_rdata;

  // Two-flop synchronizers for the asynchronous CAMAC ack and LAM lines
  always_ff @(posedge isa_clk or negedge isa_reset) begin
    if (!isa_reset) begin
      r_prr_meta <= 1'b1;
      r_prr_s    <= 1'b1;
      r_zk4_meta <= 1'b1;
      r_zk4_s    <= 1'b1;
      r_zk4_prev <= 1'b1;
    end else begin
      r_prr_meta <= bus.cb_prr;
      r_prr_s    <= r_prr_meta;
      r_zk4_meta <= bus.cb_zk4;
      r_zk4_s    <= r_zk4_meta;
      r_zk4_prev <= r_zk4_s;
    end
  end

  // FSM state, shared setup/strobe counter, ack-capture and timeout status
  always_ff @(posedge isa_clk or negedge isa_reset) begin
    if (!isa_reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 8'd0;
      r_to_flag   <= 1'b0;
      r_rdata_cap <= 16'h0000;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_to_flag   <= w_to_flag_nxt;
      r_rdata_cap <= w_rdata_cap_nxt;
    end
  end

  // Next-state logic; ack is checked before the timeout so a late ack wins
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_to_flag_nxt   = r_to_flag;
    w_rdata_cap_nxt = r_rdata_cap;
    w_accept        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_SETUP;
          w_cnt_nxt   = 8'd0;
        end
      end
      S_SETUP: begin
        if (r_cnt == C_SETUP_LAST) begin
          w_state_nxt = S_STROBE;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_STROBE: begin
        if (!r_prr_s) begin
          w_state_nxt   = S_RELEASE;
          w_to_flag_nxt = 1'b0;
          if (!r_write) begin
            w_rdata_cap_nxt = bus.cb_data_in;
          end
        end else if (r_cnt == C_TMO_LAST) begin
          w_state_nxt   = S_RELEASE;
          w_to_flag_nxt = 1'b1;
          if (!r_write) begin
            w_rdata_cap_nxt = 16'hFFFF;
          end
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_RELEASE: w_state_nxt = S_DONE;
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Direction of the cycle being entered: a new request's, else the latched one
  always_comb begin
    w_write_nxt = r_write;
    if (w_accept) begin
      w_write_nxt = bus.req_write;
    end
  end

  // Latch address, write data and direction when a request is accepted
  always_ff @(posedge isa_clk or negedge isa_reset) begin
    if (!isa_reset) begin
      r_cb_addr     <= 12'h000;
      r_cb_data_out <= 16'h0000;
      r_write       <= 1'b0;
    end else if (w_accept) begin
      r_cb_addr     <= bus.req_addr;
      r_cb_data_out <= bus.req_wdata;
      r_write       <= bus.req_write;
    end
  end

  // Registered outputs decoded from the state being entered, so they align with it
  always_ff @(posedge isa_clk or negedge isa_reset) begin
    if (!isa_reset) begin
      r_req_ready   <= 1'b1;
      r_cb_b_b1     <= 1'b1;
      r_cb_data_oe  <= 1'b0;
      r_isa_chrdy   <= 1'b1;
      r_rsp_valid   <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_rsp_rdata   <= 16'h0000;
    end else begin
      r_req_ready  <= (w_state_nxt == S_IDLE);
      r_cb_b_b1    <= (w_state_nxt != S_STROBE);
      r_isa_chrdy  <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_DONE);
      r_cb_data_oe <= w_write_nxt && ((w_state_nxt == S_SETUP) ||
                                      (w_state_nxt == S_STROBE) ||
                                      (w_state_nxt == S_RELEASE));
      r_rsp_valid  <= (w_state_nxt == S_DONE);
      if (w_state_nxt == S_DONE) begin
        r_rsp_timeout <= r_to_flag;
        if (!r_write) begin
          r_rsp_rdata <= r_rdata_cap;
        end
      end
    end
  end

  assign w_zk4_fall = r_zk4_prev & ~r_zk4_s;

  // Sticky LAM flag; a new LAM edge beats a coincident clear
  always_ff @(posedge isa_clk or negedge isa_reset) begin
    if (!isa_reset) begin
      r_lam_pending <= 1'b0;
    end else if (w_zk4_fall) begin
      r_lam_pending <= 1'b1;
    end else if (bus.lam_ack) begin
      r_lam_pending <= 1'b0;
    end
  end

  assign bus.req_ready   = r_req_ready;
  assign bus.cb_addr     = r_cb_addr;
  assign bus.cb_data_out = r_cb_data_out;
  assign bus.cb_data_oe  = r_cb_data_oe;
  assign bus.cb_b_b1     = r_cb_b_b1;
  assign bus.isa_chrdy   = r_isa_chrdy;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_rdata   = r_rsp_rdata;
  assign bus.rsp_timeout = r_rsp_timeout;
  assign bus.lam_pending = r_lam_pending;

endmodule
`default_nettype wire
